// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: execute-stage pipeline control.
// Tracks EX/MEM/WB destination shadows, produces registered operand-forward
// selects for EX, inserts a one-cycle bubble on load-use and squashes ID on
// a taken branch resolved in EX.
//
// Ports:
//   clk, reset          rising-edge clock, async active-low reset
//   id_valid            ID holds a real instruction
//   id_Rn/id_Rm         source registers, qualified by id_uses_Rn/id_uses_Rm
//   id_Rd               destination register
//   id_RegWrite         ID instruction writes Rd
//   id_MemRead          ID instruction is a load
//   br_taken_ex         branch in EX resolved taken this cycle
//   forwardA/forwardB   EX operand selects (00 reg, 01 MEM, 10 WB), registered
//   stall               hold PC and IF/ID (combinational)
//   flush               discard IF/ID (combinational)
//   ex_valid            instruction in EX is real, registered
module ex_hazard_ctrl #(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_Rn,
  input  logic [REG_W-1:0] id_Rm,
  input  logic             id_uses_Rn,
  input  logic             id_uses_Rm,
  input  logic [REG_W-1:0] id_Rd,
  input  logic             id_RegWrite,
  input  logic             id_MemRead,
  input  logic             br_taken_ex,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
  output logic             stall,
  output logic             flush,
  output logic             ex_valid
);

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
  } shadow_t;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    LSTALL = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  shadow_t    ex_sh;
  shadow_t    mem_sh;
  shadow_t    wb_sh;
  logic       bubble;
  logic       ex_rn;
  logic       ex_rm;
  logic       mem_rn;
  logic       mem_rm;
  logic       load_use;
  logic [1:0] fwd_a_nxt;
  logic [1:0] fwd_b_nxt;

  // A stage produces src if it is a real writer of that register (never XZR).
  function automatic logic src_match(input shadow_t s, input logic [REG_W-1:0] src,
                                     input logic uses);
    return s.valid & s.reg_write & (s.rd == src) & (src != REG_W'(ZERO_REG)) & uses;
  endfunction

  assign ex_rn  = src_match(ex_sh,  id_Rn, id_uses_Rn);
  assign ex_rm  = src_match(ex_sh,  id_Rm, id_uses_Rm);
  assign mem_rn = src_match(mem_sh, id_Rn, id_uses_Rn);
  assign mem_rm = src_match(mem_sh, id_Rm, id_uses_Rm);

  assign load_use = id_valid & ex_sh.mem_read & (ex_rn | ex_rm);

  // Next-cycle selects: EX producer will be in MEM, MEM producer in WB.
  // The younger (EX) producer wins; a load in EX cannot forward yet.
  always_comb begin
    fwd_a_nxt = FWD_REG;
    fwd_b_nxt = FWD_REG;
    if (id_valid) begin
      if (ex_rn && !ex_sh.mem_read) fwd_a_nxt = FWD_MEM;
      else if (mem_rn)              fwd_a_nxt = FWD_WB;
      if (ex_rm && !ex_sh.mem_read) fwd_b_nxt = FWD_MEM;
      else if (mem_rm)              fwd_b_nxt = FWD_WB;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:    if (!br_taken_ex && load_use) state_nxt = LSTALL;
      LSTALL: state_nxt = RUN;
    endcase
  end

  // Control outputs; a flush outranks a load-use stall, and reset silences both.
  always_comb begin
    stall  = 1'b0;
    flush  = 1'b0;
    bubble = 1'b0;
    if (reset) begin
      unique case (state)
        RUN: begin
          if (br_taken_ex) begin
            flush  = 1'b1;
            bubble = 1'b1;
          end else if (load_use) begin
            stall  = 1'b1;
            bubble = 1'b1;
          end
        end
        LSTALL: begin
          if (br_taken_ex) begin
            flush  = 1'b1;
            bubble = 1'b1;
          end
        end
      endcase
    end
  end

  // Shadow pipeline and registered forward selects
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_sh    <= '0;
      mem_sh   <= '0;
      wb_sh    <= '0;
      forwardA <= FWD_REG;
      forwardB <= FWD_REG;
    end else begin
      if (bubble || !id_valid) ex_sh <= '0;
      else ex_sh <= shadow_t'{valid: 1'b1, rd: id_Rd, reg_write: id_RegWrite,
                              mem_read: id_MemRead};
      mem_sh   <= ex_sh;
      wb_sh    <= mem_sh;
      forwardA <= bubble ? FWD_REG : fwd_a_nxt;
      forwardB <= bubble ? FWD_REG : fwd_b_nxt;
    end
  end

  assign ex_valid = ex_sh.valid;

  // Bubbles enter as all-zero, so an invalid shadow never carries control bits.
  a_clean_shadows: assert property (@(posedge clk) disable iff (!reset)
    (mem_sh.valid || mem_sh == '0) && (wb_sh.valid || wb_sh == '0));

endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
- Pipeline control block for the execute stage. Tracks the destination registers of instructions in EX, MEM and WB, and produces registered forwardA/forwardB selects for the EX operand muxes.
- Detects load-use hazards and inserts a one-cycle bubble.
- Squashes the ID instruction when EX resolves a taken branch.
- Sits between the decoder (ID) and the EX-stage datapath. Drives IF/ID stall and flush and the EX valid qualifier.

Parameters:
- REG_W, 5, register index width.
- ZERO_REG, 31, index of the hard-wired zero register (XZR); never forwarded, never a hazard.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- id_valid  input  1  ID holds a real instruction.
- id_Rn  input  REG_W  first source register.
- id_Rm  input  REG_W  second source register.
- id_uses_Rn  input  1  instruction reads Rn.
- id_uses_Rm  input  1  instruction reads Rm as the ALU B operand (ALUsrc selects register).
- id_Rd  input  REG_W  destination register.
- id_RegWrite  input  1  instruction writes Rd.
- id_MemRead  input  1  instruction is a load.
- br_taken_ex  input  1  branch in EX resolved taken this cycle.
- forwardA  output  2  EX operand A select: 00 reg, 01 MEM result, 10 WB result; 11 unused.
- forwardB  output  2  EX operand B select, same encoding.
- stall  output  1  hold PC and the IF/ID register this cycle.
- flush  output  1  discard the IF/ID contents this cycle.
- ex_valid  output  1  instruction currently in EX is real; gates flag update and RegWrite.

Behaviour:
- Reset (reset=0, async):
  - forwardA=forwardB=00, ex_valid=0.
  - All shadow valid/RegWrite/MemRead bits cleared; state=RUN.
  - stall and flush deassert immediately.
- Shadow pipeline:
  - Three register sets (EX, MEM, WB), each holding {valid, Rd, RegWrite, MemRead}. They advance every rising edge: ID→EX→MEM→WB.
  - WB shadow drops off after one cycle.
  - ex_valid is the EX shadow valid.
- Hazard detection (combinational, in the ID cycle):
  - match(stage, src) = stage.valid & stage.RegWrite & stage.Rd==src & src!=ZERO_REG & uses_src.
  - load_use = id_valid & EX.MemRead & (match(EX,Rn) | match(EX,Rm)).
- Forwarding (computed in ID, registered, valid during EX):
  - next forwardA = 01 if match(EX,Rn) & !EX.MemRead; else 10 if match(MEM,Rn); else 00.
  - The ID instruction's EX-stage producer is in MEM next cycle, and its MEM-stage producer is in WB next cycle.
  - Younger producer wins: MEM priority over WB.
  - forwardB is identical using Rm/id_uses_Rm.
  - Selects load only when ID advances. During a stall or flush, forward registers load 00.
- State machine:
  - RUN:
    - br_taken_ex=1 → flush=1, stall=0; EX shadow loads a bubble (valid=0); state stays RUN.
    - else load_use=1 → stall=1; EX shadow loads a bubble; go to LSTALL.
    - else advance normally.
  - LSTALL:
    - stall=0. The load is now in MEM, and the re-evaluated ID forwards from WB (10).
    - br_taken_ex has priority (flush, bubble).
    - Return to RUN next edge.
- Boundary cases:
  - Flush and load_use in the same cycle: flush wins, stall=0.
  - Rd=ZERO_REG never matches.
  - id_valid=0 never stalls and advances a bubble.
  - Back-to-back loads each using the previous load: one bubble per pair.
  - Stall is at most 1 cycle per instruction.
  - Reset mid-LSTALL returns to RUN with all shadows invalid.

Test Plan:
- Reset released; ID: ADD X1,X2,X3, RegWrite → after 1 edge ex_valid=1, forwardA=forwardB=00, stall=0.
- ADD X1,X2,X3 then SUB X4,X1,X5 → SUB's EX cycle has forwardA=01, forwardB=00. With X5 replaced by X1: both 01.
- ADD X1; NOP; SUB X4,X1,X1 → forwardA=forwardB=10. ADD X1, ADD X1, SUB uses X1 → 01 (MEM priority).
- LDUR X2 then ADD X3,X2,X4 → stall=1 one cycle, ex_valid=0 next cycle, then ADD in EX with forwardA=10. ADD X31 destination → no forwarding, no stall.
- br_taken_ex=1 with a load-use pending in ID → flush=1, stall=0, next ex_valid=0, forwards 00.
- reset pulsed low during LSTALL → outputs zero immediately, the next instruction issues with no stall.
